// File: rtl/pe_chain.sv
// Systolic chain of TAPS multiply-accumulate stages (transposed-form correlation).
// One pixel is broadcast to every tap per accepted beat; partial sums ripple toward y_out.
module pe_chain #(
  parameter int TAPS   = 3,
  parameter int PIX_W  = 8,
  parameter int ACC_W  = 16,
  parameter int W_W    = 3,
  parameter int SAT_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    w_load,
  input  logic signed [W_W-1:0]   w_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_W-1:0]        x_in,
  input  logic signed [ACC_W-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] y_out,
  output logic                    sat_flag
);

  localparam int SUM_W = ACC_W + 2;
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic signed [SUM_W-1:0] SUM_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {3'b111, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] s     [TAPS];
  logic signed [ACC_W-1:0] s_nxt [TAPS];
  logic signed [W_W-1:0]   w     [TAPS];
  logic [TAPS-1:0]         sat_hit;
  logic [CNT_W-1:0]        fill_cnt;
  logic signed [SUM_W-1:0] x_ext;
  logic                    adv;

  assign in_ready = !clear && !w_load && (!out_valid || out_ready);
  assign adv      = in_valid && in_ready;
  assign y_out    = s[TAPS-1];
  assign x_ext    = $signed(SUM_W'({1'b0, x_in}));

  for (genvar k = 0; k < TAPS; k++) begin : g_stage
    logic signed [ACC_W-1:0] prev;
    logic signed [SUM_W-1:0] sum;
    logic signed [ACC_W-1:0] nxt;
    logic                    sat;

    if (k == 0) begin : g_head
      assign prev = y_in;
    end else begin : g_body
      assign prev = s[k-1];
    end

    // Two guard bits: the sum of an ACC_W operand and a small product cannot overflow SUM_W.
    assign sum = SUM_W'(prev) + SUM_W'(w[k]) * x_ext;

    always_comb begin
      nxt = sum[ACC_W-1:0];
      sat = 1'b0;
      if (SAT_EN != 0 && sum[SUM_W-1:ACC_W-1] != {3{sum[SUM_W-1]}}) begin
        nxt = sum[SUM_W-1] ? SUM_MIN[ACC_W-1:0] : SUM_MAX[ACC_W-1:0];
        sat = 1'b1;
      end
    end

    assign s_nxt[k]   = nxt;
    assign sat_hit[k] = sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        s[k] <= '0;
        w[k] <= '0;
      end
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      // Weight shifting is independent of clear so both can happen together.
      if (w_load) begin
        for (int k = 0; k < TAPS - 1; k++) w[k] <= w[k+1];
        w[TAPS-1] <= w_data;
      end
      if (clear) begin
        for (int k = 0; k < TAPS; k++) s[k] <= '0;
        fill_cnt  <= '0;
        out_valid <= 1'b0;
        sat_flag  <= 1'b0;
      end else if (adv) begin
        for (int k = 0; k < TAPS; k++) s[k] <= s_nxt[k];
        if (fill_cnt != CNT_W'(TAPS)) fill_cnt <= fill_cnt + CNT_W'(1);
        out_valid <= (int'(fill_cnt) + 1 >= TAPS);
        if (|sat_hit) sat_flag <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
